// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared state encoding for the pipeline skid register
package pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } skid_state_t;

    // Encoding 2'd3 is never entered; report it as empty so outputs stay sane.
    function automatic logic [1:0] state_occupancy(skid_state_t s);
        case (s)
            ONE:     state_occupancy = 2'd1;
            FULL:    state_occupancy = 2'd2;
            default: state_occupancy = 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/pipe_data_reg.sv
// rtl/pipe_data_reg.sv - payload register with load enable and synchronous clear
module pipe_data_reg #(
    parameter int              WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q <= RESET_VAL;
        end else if (clr) begin
            q <= RESET_VAL;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/pipeline_skid_reg.sv
// rtl/pipeline_skid_reg.sv - valid/ready pipeline stage with 2-entry skid buffer and flush
module pipeline_skid_reg
    import pipe_pkg::*;
#(
    parameter int               WIDTH          = 32,
    parameter logic [WIDTH-1:0] RESET_VAL      = '0,
    parameter int               CLEAR_ON_FLUSH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       occupancy
);

    skid_state_t      state_q;
    skid_state_t      state_d;
    logic             accept;
    logic             drain;
    logic             main_load;
    logic             skid_load;
    logic             main_sel_skid;
    logic             data_clr;
    logic [WIDTH-1:0] main_d;
    logic [WIDTH-1:0] skid_q;

    // Handshake outputs come straight from the state flops: no path from out_ready.
    assign in_ready  = (state_q != FULL);
    assign out_valid = (state_q == ONE) || (state_q == FULL);
    assign occupancy = state_occupancy(state_q);

    assign accept = in_valid & in_ready;
    assign drain  = out_valid & out_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        main_load     = 1'b0;
        skid_load     = 1'b0;
        main_sel_skid = 1'b0;
        data_clr      = 1'b0;
        if (flush) begin
            state_d  = EMPTY;
            data_clr = (CLEAR_ON_FLUSH != 0);
        end else begin
            case (state_q)
                EMPTY: begin
                    if (accept) begin
                        state_d   = ONE;
                        main_load = 1'b1;
                    end
                end
                ONE: begin
                    case ({accept, drain})
                        2'b11: main_load = 1'b1;
                        2'b10: begin
                            state_d   = FULL;
                            skid_load = 1'b1;
                        end
                        2'b01: state_d = EMPTY;
                        default: state_d = ONE;
                    endcase
                end
                FULL: begin
                    if (drain) begin
                        state_d       = ONE;
                        main_load     = 1'b1;
                        main_sel_skid = 1'b1;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    assign main_d = main_sel_skid ? skid_q : in_data;

    pipe_data_reg #(
        .WIDTH     (WIDTH),
        .RESET_VAL (RESET_VAL)
    ) u_main (
        .clk  (clk),
        .rst  (rst),
        .clr  (data_clr),
        .load (main_load),
        .d    (main_d),
        .q    (out_data)
    );

    pipe_data_reg #(
        .WIDTH     (WIDTH),
        .RESET_VAL (RESET_VAL)
    ) u_skid (
        .clk  (clk),
        .rst  (rst),
        .clr  (data_clr),
        .load (skid_load),
        .d    (in_data),
        .q    (skid_q)
    );

endmodule

// File: tb/tb_pipeline_skid_reg.sv
// tb/tb_pipeline_skid_reg.sv - directed, table-driven and random checks of pipeline_skid_reg
module tb_pipeline_skid_reg;

    localparam logic [31:0] RV32 = 32'hDEAD_BEEF;
    localparam logic [63:0] RV64 = {64{1'b1}};
    localparam logic [0:0]  RV1  = 1'b1;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        out_ready;
    logic [63:0] in_data;

    logic        ir32, ov32, ir64, ov64, ir1, ov1;
    logic [1:0]  occ32, occ64, occ1;
    logic [31:0] od32;
    logic [63:0] od64;
    logic [0:0]  od1;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    pipeline_skid_reg #(.WIDTH(32), .RESET_VAL(RV32), .CLEAR_ON_FLUSH(1)) dut32 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(ir32),
        .in_data(in_data[31:0]), .out_valid(ov32), .out_ready(out_ready),
        .out_data(od32), .occupancy(occ32));

    pipeline_skid_reg #(.WIDTH(64), .RESET_VAL(RV64), .CLEAR_ON_FLUSH(0)) dut64 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(ir64),
        .in_data(in_data), .out_valid(ov64), .out_ready(out_ready),
        .out_data(od64), .occupancy(occ64));

    pipeline_skid_reg #(.WIDTH(1), .RESET_VAL(RV1), .CLEAR_ON_FLUSH(1)) dut1 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(ir1),
        .in_data(in_data[0:0]), .out_valid(ov1), .out_ready(out_ready),
        .out_data(od1), .occupancy(occ1));

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_ctrl(input string tag, input logic exp_ov, input logic exp_ir,
                              input logic [1:0] exp_occ);
        check({tag, " out_valid"}, {63'd0, ov32}, {63'd0, exp_ov});
        check({tag, " in_ready"}, {63'd0, ir32}, {63'd0, exp_ir});
        check({tag, " occupancy"}, {62'd0, occ32}, {62'd0, exp_occ});
        check({tag, " ctrl64"}, {60'd0, ov64, ir64, occ64}, {60'd0, exp_ov, exp_ir, exp_occ});
        check({tag, " ctrl1"}, {60'd0, ov1, ir1, occ1}, {60'd0, exp_ov, exp_ir, exp_occ});
    endtask

    task automatic drive(input logic iv, input logic ordy, input logic fl, input logic [63:0] d);
        in_valid  = iv;
        out_ready = ordy;
        flush     = fl;
        in_data   = d;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        iv;
        logic        ordy;
        logic        fl;
        logic [63:0] d;
        logic        exp_ov;
        logic        exp_ir;
        logic [1:0]  exp_occ;
        logic [31:0] exp_d32;
        logic [63:0] exp_d64;
    } vec_t;

    vec_t vecs[13];
    logic [63:0] q[$];
    logic [63:0] prev64;
    logic        prev_stall;
    int          acc_cnt;

    initial begin
        // Backpressure, skid fill/drain, streaming handoff and flush, expected after each edge.
        vecs[0]  = '{1, 0, 0, 64'hA, 1, 1, 2'd1, 32'hA, 64'hA};
        vecs[1]  = '{1, 0, 0, 64'hB, 1, 0, 2'd2, 32'hA, 64'hA};
        vecs[2]  = '{1, 0, 0, 64'hC, 1, 0, 2'd2, 32'hA, 64'hA};
        vecs[3]  = '{0, 1, 0, 64'h0, 1, 1, 2'd1, 32'hB, 64'hB};
        vecs[4]  = '{0, 1, 0, 64'h0, 0, 1, 2'd0, 32'hB, 64'hB};
        vecs[5]  = '{1, 1, 0, 64'h1, 1, 1, 2'd1, 32'h1, 64'h1};
        vecs[6]  = '{1, 1, 0, 64'h2, 1, 1, 2'd1, 32'h2, 64'h2};
        vecs[7]  = '{1, 0, 0, 64'h3, 1, 0, 2'd2, 32'h2, 64'h2};
        vecs[8]  = '{1, 0, 1, 64'hC, 0, 1, 2'd0, RV32,  64'h2};
        vecs[9]  = '{0, 1, 0, 64'h0, 0, 1, 2'd0, RV32,  64'h2};
        vecs[10] = '{1, 0, 0, 64'h5, 1, 1, 2'd1, 32'h5, 64'h5};
        vecs[11] = '{1, 1, 1, 64'h6, 0, 1, 2'd0, RV32,  64'h5};
        vecs[12] = '{0, 0, 0, 64'h0, 0, 1, 2'd0, RV32,  64'h5};

        rst = 1'b0;
        drive(0, 0, 0, 64'h0);
        #12;
        check_ctrl("reset", 0, 1, 2'd0);
        check("reset data32", {32'd0, od32}, {32'd0, RV32});
        check("reset data64", od64, RV64);
        check("reset data1", {63'd0, od1}, {63'd0, RV1});
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 13; i++) begin
            drive(vecs[i].iv, vecs[i].ordy, vecs[i].fl, vecs[i].d);
            step();
            check_ctrl($sformatf("vec%0d", i), vecs[i].exp_ov, vecs[i].exp_ir, vecs[i].exp_occ);
            check($sformatf("vec%0d data32", i), {32'd0, od32}, {32'd0, vecs[i].exp_d32});
            check($sformatf("vec%0d data64", i), od64, vecs[i].exp_d64);
        end

        // Async reset while full: outputs must return at once, not on the next edge.
        drive(1, 0, 0, 64'h11);
        step();
        drive(1, 0, 0, 64'h22);
        step();
        check("prereset occupancy", {62'd0, occ32}, 64'd2);
        #2;
        rst = 1'b0;
        #1;
        check_ctrl("async reset", 0, 1, 2'd0);
        check("async reset data32", {32'd0, od32}, {32'd0, RV32});
        check("async reset data64", od64, RV64);
        check("async reset data1", {63'd0, od1}, {63'd0, RV1});
        @(negedge clk);
        rst = 1'b1;

        // Streaming: one transfer per cycle, no bubbles.
        for (int k = 1; k <= 100; k++) begin
            drive(1, 1, 0, 64'(k));
            step();
            check_ctrl($sformatf("stream%0d", k), 1, 1, 2'd1);
            check($sformatf("stream%0d data32", k), {32'd0, od32}, 64'(k));
            check($sformatf("stream%0d data1", k), {63'd0, od1}, {63'd0, 1'(k)});
        end
        drive(0, 1, 0, 64'h0);
        step();
        check_ctrl("stream drain", 0, 1, 2'd0);

        // Random traffic against a queue model.
        q.delete();
        prev_stall = 1'b0;
        prev64     = '0;
        acc_cnt    = 0;
        for (int c = 0; c < 10000; c++) begin
            logic iv, ordy, fl, acc, drn;
            logic [63:0] d;
            iv   = ($urandom_range(0, 3) != 0);
            ordy = ($urandom_range(0, 2) != 0);
            fl   = ($urandom_range(0, 31) == 0);
            d    = {$urandom, $urandom};
            drive(iv, ordy, fl, d);
            acc = iv && (q.size() < 2);
            drn = ordy && (q.size() > 0);
            prev_stall = (q.size() > 0) && !ordy && !fl;
            prev64     = od64;
            if (fl) begin
                q.delete();
            end else begin
                if (drn) void'(q.pop_front());
                if (acc) begin
                    q.push_back(d);
                    acc_cnt++;
                end
            end
            step();
            check_ctrl($sformatf("rand%0d", c), q.size() > 0, q.size() < 2, 2'(q.size()));
            if (q.size() > 0) begin
                check($sformatf("rand%0d data64", c), od64, q[0]);
                check($sformatf("rand%0d data32", c), {32'd0, od32}, {32'd0, q[0][31:0]});
                check($sformatf("rand%0d data1", c), {63'd0, od1}, {63'd0, q[0][0]});
            end
            if (prev_stall) begin
                check($sformatf("rand%0d stall hold", c), od64, prev64);
            end
        end
        check("random accepts seen", {63'd0, acc_cnt > 1000}, 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL timeout: simulation did not finish, got running, expected done");
        $fatal(1);
    end

endmodule
